// File: rtl/decrypt.sv
// Paillier-style decryptor: m = L(c^lambda mod n^2) * mu mod n.
// The engine runs MSB-first square-and-multiply with a fixed 2*LAMBDA_WIDTH+2 cycle latency.
module decrypt #(
    parameter int DATA_WIDTH   = 10,
    parameter int N_WIDTH      = 10,
    parameter int LAMBDA_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vld_in,
    input  logic [2*N_WIDTH-1:0]      ciphertext,
    input  logic [LAMBDA_WIDTH-1:0]   lambda,
    input  logic [N_WIDTH-1:0]        mu,
    input  logic [N_WIDTH-1:0]        n,
    output logic [DATA_WIDTH-1:0]     plaintext,
    output logic                      done,
    output logic                      err,
    output logic                      busy
);

    localparam int W2    = 2 * N_WIDTH;
    localparam int W4    = 4 * N_WIDTH;
    localparam int IDX_W = (LAMBDA_WIDTH > 1) ? $clog2(LAMBDA_WIDTH) : 1;

    localparam logic [IDX_W-1:0]   IdxTop = IDX_W'(LAMBDA_WIDTH - 1);
    localparam logic [IDX_W-1:0]   IdxOne = IDX_W'(1);
    localparam logic [W2-1:0]      AccOne = W2'(1);
    localparam logic [N_WIDTH-1:0] NOne   = N_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StExpSqr,
        StExpMul,
        StLfun,
        StMulmu
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LAMBDA_WIDTH-1:0] r_lambda;
    logic [N_WIDTH-1:0]      r_mu;
    logic [N_WIDTH-1:0]      r_n;
    logic [W2-1:0]           r_nsq;
    logic [W2-1:0]           r_c;
    logic [W2-1:0]           r_acc;
    logic [IDX_W-1:0]        r_idx;
    logic [N_WIDTH-1:0]      r_u;
    logic [DATA_WIDTH-1:0]   r_plaintext;
    logic                    r_done;
    logic                    r_err;
    logic                    r_busy;

    logic                    w_accept;
    logic                    w_n_small_in;
    logic                    w_n_small;
    logic [W2-1:0]           w_nsq_in;
    logic [W2-1:0]           w_nsq_in_div;
    logic [W2-1:0]           w_c_in;
    logic [W2-1:0]           w_nsq_div;
    logic [N_WIDTH-1:0]      w_n_div;
    logic [W4-1:0]           w_sq_full;
    logic [W4-1:0]           w_mul_full;
    logic [W2-1:0]           w_lfun_full;
    logic [N_WIDTH-1:0]      w_u;
    logic [W2-1:0]           w_mm_full;
    logic [DATA_WIDTH-1:0]   w_pt;

    assign w_accept     = (r_state == StIdle) && vld_in;
    assign w_n_small_in = (n[N_WIDTH-1:1] == '0);
    assign w_n_small    = (r_n[N_WIDTH-1:1] == '0);

    // Divisors are forced non-zero so idle/err-path arithmetic never divides by zero.
    assign w_nsq_in     = {{N_WIDTH{1'b0}}, n} * {{N_WIDTH{1'b0}}, n};
    assign w_nsq_in_div = w_n_small_in ? AccOne : w_nsq_in;
    assign w_c_in       = w_n_small_in ? '0 : (ciphertext % w_nsq_in_div);
    assign w_nsq_div    = (r_nsq == '0) ? AccOne : r_nsq;
    assign w_n_div      = w_n_small ? NOne : r_n;

    assign w_sq_full  = ({{W2{1'b0}}, r_acc} * {{W2{1'b0}}, r_acc}) % {{W2{1'b0}}, w_nsq_div};
    assign w_mul_full = ({{W2{1'b0}}, r_acc} * {{W2{1'b0}}, r_c}) % {{W2{1'b0}}, w_nsq_div};

    // acc < n^2, so (acc-1)/n always fits in N_WIDTH bits.
    assign w_lfun_full = (r_acc - AccOne) / {{N_WIDTH{1'b0}}, w_n_div};
    assign w_u         = (r_acc == '0) ? '0 : w_lfun_full[N_WIDTH-1:0];

    assign w_mm_full = ({{N_WIDTH{1'b0}}, r_u} * {{N_WIDTH{1'b0}}, r_mu})
                       % {{N_WIDTH{1'b0}}, w_n_div};
    assign w_pt      = w_mm_full[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (vld_in) begin
                    w_state_nxt = w_n_small_in ? StMulmu : StExpSqr;
                end
            end
            StExpSqr: w_state_nxt = StExpMul;
            StExpMul: w_state_nxt = (r_idx == '0) ? StLfun : StExpSqr;
            StLfun:   w_state_nxt = StMulmu;
            StMulmu:  w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lambda    <= '0;
            r_mu        <= '0;
            r_n         <= '0;
            r_nsq       <= '0;
            r_c         <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_u         <= '0;
            r_plaintext <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_lambda <= lambda;
                        r_mu     <= mu;
                        r_n      <= n;
                        r_nsq    <= w_nsq_in;
                        r_c      <= w_c_in;
                        r_acc    <= AccOne;
                        r_idx    <= IdxTop;
                        r_u      <= '0;
                        r_busy   <= 1'b1;
                        r_err    <= 1'b0;
                    end
                end
                StExpSqr: begin
                    r_acc <= w_sq_full[W2-1:0];
                end
                StExpMul: begin
                    if (r_lambda[r_idx]) begin
                        r_acc <= w_mul_full[W2-1:0];
                    end
                    if (r_idx != '0) begin
                        r_idx <= r_idx - IdxOne;
                    end
                end
                StLfun: begin
                    r_u <= w_u;
                end
                StMulmu: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_n_small) begin
                        r_plaintext <= '0;
                        r_err       <= 1'b1;
                    end else begin
                        r_plaintext <= w_pt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign plaintext = r_plaintext;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_decrypt.sv
// Scoreboarded bench for decrypt: stimulus pushes expected results, a monitor pops on done.
module tb_decrypt;

    logic        clk;
    logic        rst_n;
    logic        vld_in;
    logic [19:0] ciphertext;
    logic [9:0]  lambda;
    logic [9:0]  mu;
    logic [9:0]  n;
    logic [9:0]  plaintext;
    logic        done;
    logic        err;
    logic        busy;

    decrypt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vld_in     (vld_in),
        .ciphertext (ciphertext),
        .lambda     (lambda),
        .mu         (mu),
        .n          (n),
        .plaintext  (plaintext),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    typedef struct {
        logic [9:0] pt;
        logic       er;
        int         due;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("plaintext", int'(plaintext), int'(q[0].pt));
                check("err", int'(err), int'(q[0].er));
                check("latency", cyc, q[0].due);
                void'(q.pop_front());
            end
        end else if (q.size() != 0 && cyc > q[0].due) begin
            check("done_timeout", cyc, q[0].due);
            void'(q.pop_front());
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic req(input logic [19:0] c, input logic [9:0] lam, input logic [9:0] m,
                       input logic [9:0] nn, input logic [9:0] exp_pt, input logic exp_er,
                       input int lat, input bit push);
        exp_t e;
        wait_idle();
        ciphertext = c;
        lambda     = lam;
        mu         = m;
        n          = nn;
        vld_in     = 1'b1;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        if (push) begin
            e.pt  = exp_pt;
            e.er  = exp_er;
            e.due = cyc + lat;
            q.push_back(e);
        end
        check("busy_after_accept", int'(busy), 1);
        check("err_cleared_on_accept", int'(err), 0);
    endtask

    initial begin
        exp_t e;
        int   k;
        rst_n      = 1'b0;
        vld_in     = 1'b0;
        ciphertext = '0;
        lambda     = '0;
        mu         = '0;
        n          = '0;
        repeat (3) @(negedge clk);
        check("rst_plaintext", int'(plaintext), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // T1, T2, T3
        req(20'd83, 10'd4, 10'd4, 10'd15, 10'd7, 1'b0, 22, 1'b1);
        req(20'd143, 10'd4, 10'd4, 10'd15, 10'd0, 1'b0, 22, 1'b1);
        req(20'd308, 10'd4, 10'd4, 10'd15, 10'd7, 1'b0, 22, 1'b1);
        // lambda == 0 and an n=7 vector: 10^6 mod 49 = 8, L=1, 1*3 mod 7 = 3
        req(20'd83, 10'd0, 10'd4, 10'd15, 10'd0, 1'b0, 22, 1'b1);
        req(20'd10, 10'd6, 10'd3, 10'd7, 10'd3, 1'b0, 22, 1'b1);

        // T4: n<2 error path, then a good request clears err at accept
        req(20'd83, 10'd4, 10'd4, 10'd1, 10'd0, 1'b1, 1, 1'b1);
        wait_idle();
        @(negedge clk);
        check("err_held", int'(err), 1);
        req(20'd83, 10'd4, 10'd4, 10'd15, 10'd7, 1'b0, 22, 1'b1);
        req(20'd83, 10'd4, 10'd4, 10'd0, 10'd0, 1'b1, 1, 1'b1);

        // vld pulse while busy must be ignored
        req(20'd83, 10'd4, 10'd4, 10'd15, 10'd7, 1'b0, 22, 1'b1);
        repeat (5) @(negedge clk);
        ciphertext = 20'd143;
        vld_in     = 1'b1;
        @(negedge clk);
        vld_in = 1'b0;

        // T5: vld held for 60 edges -> accepts every 23 cycles
        wait_idle();
        ciphertext = 20'd83;
        lambda     = 10'd4;
        mu         = 10'd4;
        n          = 10'd15;
        vld_in     = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            e.pt  = 10'd7;
            e.er  = 1'b0;
            e.due = cyc + 22 + 23 * i;
            q.push_back(e);
        end
        repeat (59) @(posedge clk);
        #1;
        vld_in = 1'b0;

        // T6: reset mid-operation aborts with no done
        req(20'd83, 10'd4, 10'd4, 10'd15, 10'd7, 1'b0, 22, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_plaintext", int'(plaintext), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err), 0);
        check("abort_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        req(20'd83, 10'd4, 10'd4, 10'd15, 10'd7, 1'b0, 22, 1'b1);

        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("queue_drained", q.size(), 0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
